// File: rtl/ppu_pkg.sv
// Shared PPU definitions: mode encoding, memory map constants and read-source mux.
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_e;

  // Where a registered read takes its byte from on the following cycle
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_FF   = 2'd1,
    SRC_VRAM = 2'd2,
    SRC_OAM  = 2'd3
  } rd_src_e;

  localparam logic [15:0] VRAM_BASE = 16'h8000;
  localparam logic [15:0] VRAM_END  = 16'h9FFF;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] OAM_END   = 16'hFE9F;
  localparam logic [15:0] HOLE_END  = 16'hFEFF;

  function automatic logic [7:0] rd_mux(input rd_src_e src, input logic [7:0] vram_q,
                                        input logic [7:0] oam_q);
    logic [7:0] res;
    res = 8'h00;
    case (src)
      SRC_ZERO: res = 8'h00;
      SRC_FF:   res = 8'hFF;
      SRC_VRAM: res = vram_q;
      SRC_OAM:  res = oam_q;
      default:  res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ppu_vram_responder_if.sv
// PPU fetch, CPU MMIO and OAM DMA signals seen by the VRAM/OAM responder.
interface ppu_vram_responder_if;
  logic        PPU_RD;
  logic [15:0] PPU_ADDR;
  logic [7:0]  PPU_DATA_in;
  logic [1:0]  PPU_MODE;
  logic        LCD_EN;
  logic [15:0] ADDR;
  logic        WR;
  logic        RD;
  logic [7:0]  MMIO_DATA_out;
  logic [7:0]  MMIO_DATA_in;
  logic        DMA_ACTIVE;
  logic        DMA_WR;
  logic [7:0]  DMA_IDX;
  logic [7:0]  DMA_DATA;

  modport master (
    output PPU_RD, PPU_ADDR, PPU_MODE, LCD_EN, ADDR, WR, RD, MMIO_DATA_out,
           DMA_ACTIVE, DMA_WR, DMA_IDX, DMA_DATA,
    input  PPU_DATA_in, MMIO_DATA_in
  );

  modport slave (
    input  PPU_RD, PPU_ADDR, PPU_MODE, LCD_EN, ADDR, WR, RD, MMIO_DATA_out,
           DMA_ACTIVE, DMA_WR, DMA_IDX, DMA_DATA,
    output PPU_DATA_in, MMIO_DATA_in
  );
endinterface

// File: rtl/ppu_dpram.sv
// Synchronous true dual-port byte RAM, read-before-write on each port.
module ppu_dpram #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic [7:0]    b_rdata
);

  logic [7:0] mem [DEPTH];
  logic       a_ok;
  logic       b_ok;

  assign a_ok = (32'(a_addr) < DEPTH);
  assign b_ok = (32'(b_addr) < DEPTH);

  // Read data holds between enabled accesses; out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (a_en) begin
      a_rdata <= a_ok ? mem[a_addr] : 8'h00;
      if (a_we && a_ok) mem[a_addr] <= a_wdata;
    end
    if (b_en) begin
      b_rdata <= b_ok ? mem[b_addr] : 8'h00;
      if (b_we && b_ok) mem[b_addr] <= b_wdata;
    end
  end

endmodule

// File: rtl/ppu_vram_responder.sv
// VRAM/OAM owner: 1-cycle PPU reads, mode-locked CPU MMIO access, OAM DMA write port.
module ppu_vram_responder
  import ppu_pkg::*;
#(
  parameter int unsigned VRAM_AW  = 13,
  parameter int unsigned OAM_SIZE = 160,
  parameter bit          LOCK_EN  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  ppu_vram_responder_if.slave  bus
);

  localparam int unsigned VRAM_DEPTH = 32'd1 << VRAM_AW;
  localparam int unsigned OAM_AW     = 8;

  logic vram_sel, oam_sel, hole_sel;
  logic ppu_vram_sel, ppu_oam_sel;
  logic vram_lock, oam_lock;
  logic dma_we, cpu_vram_we, cpu_oam_we;

  logic [VRAM_AW-1:0] cpu_vram_addr, ppu_vram_addr;
  logic [OAM_AW-1:0]  cpu_oam_addr, ppu_oam_addr, oam_b_addr;
  logic [7:0]         oam_b_wdata;
  logic [7:0]         vram_a_q, vram_b_q, oam_a_q, oam_b_q;

  rd_src_e    ppu_src_q, ppu_src_d;
  rd_src_e    cpu_src_q, cpu_src_d;
  logic       cpu_vld_q;
  logic [7:0] mmio_q;

  // Decode, locks and write arbitration for the current edge
  always_comb begin
    vram_sel      = (bus.ADDR >= VRAM_BASE) && (bus.ADDR <= VRAM_END);
    oam_sel       = (bus.ADDR >= OAM_BASE) && (bus.ADDR <= OAM_END);
    hole_sel      = (bus.ADDR > OAM_END) && (bus.ADDR <= HOLE_END);
    ppu_vram_sel  = (bus.PPU_ADDR >= VRAM_BASE) && (bus.PPU_ADDR <= VRAM_END);
    ppu_oam_sel   = (bus.PPU_ADDR >= OAM_BASE) && (bus.PPU_ADDR <= OAM_END);
    vram_lock     = LOCK_EN && bus.LCD_EN && (ppu_mode_e'(bus.PPU_MODE) == DRAW);
    oam_lock      = (LOCK_EN && bus.LCD_EN && bus.PPU_MODE[1]) || bus.DMA_ACTIVE;
    cpu_vram_addr = VRAM_AW'(bus.ADDR - VRAM_BASE);
    ppu_vram_addr = VRAM_AW'(bus.PPU_ADDR - VRAM_BASE);
    cpu_oam_addr  = OAM_AW'(bus.ADDR - OAM_BASE);
    ppu_oam_addr  = OAM_AW'(bus.PPU_ADDR - OAM_BASE);
    dma_we        = bus.DMA_WR && (32'(bus.DMA_IDX) < OAM_SIZE);
    cpu_vram_we   = bus.WR && vram_sel && !vram_lock;
    cpu_oam_we    = bus.WR && oam_sel && !oam_lock && !dma_we;
    oam_b_addr    = dma_we ? bus.DMA_IDX : cpu_oam_addr;
    oam_b_wdata   = dma_we ? bus.DMA_DATA : bus.MMIO_DATA_out;
  end

  // Read source selection, captured together with the request
  always_comb begin
    ppu_src_d = SRC_ZERO;
    if (ppu_vram_sel)     ppu_src_d = SRC_VRAM;
    else if (ppu_oam_sel) ppu_src_d = bus.DMA_ACTIVE ? SRC_FF : SRC_OAM;

    // A DMA write steals OAM port B, so a coincident CPU OAM read reads as locked
    cpu_src_d = SRC_FF;
    if (vram_sel)      cpu_src_d = vram_lock ? SRC_FF : SRC_VRAM;
    else if (oam_sel)  cpu_src_d = (oam_lock || dma_we) ? SRC_FF : SRC_OAM;
    else if (hole_sel) cpu_src_d = oam_lock ? SRC_FF : SRC_ZERO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ppu_src_q <= SRC_ZERO;
      cpu_src_q <= SRC_FF;
      cpu_vld_q <= 1'b0;
      mmio_q    <= 8'hFF;
    end else begin
      if (bus.PPU_RD) ppu_src_q <= ppu_src_d;
      if (bus.RD)     cpu_src_q <= cpu_src_d;
      cpu_vld_q <= bus.RD;
      if (cpu_vld_q)  mmio_q <= rd_mux(cpu_src_q, vram_b_q, oam_b_q);
    end
  end

  assign bus.PPU_DATA_in  = rd_mux(ppu_src_q, vram_a_q, oam_a_q);
  assign bus.MMIO_DATA_in = mmio_q;

  ppu_dpram #(.AW(VRAM_AW), .DEPTH(VRAM_DEPTH)) u_vram (
    .clk     (clk),
    .a_en    (bus.PPU_RD && ppu_vram_sel),
    .a_we    (1'b0),
    .a_addr  (ppu_vram_addr),
    .a_wdata (8'h00),
    .a_rdata (vram_a_q),
    .b_en    ((bus.RD || bus.WR) && vram_sel),
    .b_we    (cpu_vram_we),
    .b_addr  (cpu_vram_addr),
    .b_wdata (bus.MMIO_DATA_out),
    .b_rdata (vram_b_q)
  );

  ppu_dpram #(.AW(OAM_AW), .DEPTH(OAM_SIZE)) u_oam (
    .clk     (clk),
    .a_en    (bus.PPU_RD && ppu_oam_sel),
    .a_we    (1'b0),
    .a_addr  (ppu_oam_addr),
    .a_wdata (8'h00),
    .a_rdata (oam_a_q),
    .b_en    (dma_we || cpu_oam_we || (bus.RD && oam_sel)),
    .b_we    (dma_we || cpu_oam_we),
    .b_addr  (oam_b_addr),
    .b_wdata (oam_b_wdata),
    .b_rdata (oam_b_q)
  );

endmodule

// File: tb/tb_ppu_vram_responder.sv
// Directed bench for ppu_vram_responder: vector table plus DMA/collision/reset sequences.
module tb_ppu_vram_responder;

  typedef enum int {OP_W, OP_R, OP_P} op_e;

  typedef struct {
    op_e         op;
    logic [1:0]  mode;
    logic        lcd;
    logic [15:0] addr;
    logic [7:0]  data;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ppu_vram_responder_if bus ();

  ppu_vram_responder #(.VRAM_AW(13), .OAM_SIZE(160), .LOCK_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", nm, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    bus.ADDR = a; bus.MMIO_DATA_out = d; bus.WR = 1'b1;
    tick();
    bus.WR = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
    bus.ADDR = a; bus.RD = 1'b1;
    tick();
    bus.RD = 1'b0;
    tick();
    d = bus.MMIO_DATA_in;
  endtask

  task automatic ppu_rd(input logic [15:0] a, output logic [7:0] d);
    bus.PPU_ADDR = a; bus.PPU_RD = 1'b1;
    tick();
    bus.PPU_RD = 1'b0;
    d = bus.PPU_DATA_in;
  endtask

  function automatic vec_t mk(input op_e op, input logic [1:0] m, input logic l,
                              input logic [15:0] a, input logic [7:0] d, input string n);
    vec_t v;
    v.op = op; v.mode = m; v.lcd = l; v.addr = a; v.data = d; v.name = n;
    return v;
  endfunction

  initial begin
    vec_t       vecs[$];
    logic [7:0] got;

    rst = 1'b1;
    bus.PPU_RD = 1'b0; bus.PPU_ADDR = 16'h0000; bus.PPU_MODE = 2'd0; bus.LCD_EN = 1'b1;
    bus.ADDR = 16'h0000; bus.WR = 1'b0; bus.RD = 1'b0; bus.MMIO_DATA_out = 8'h00;
    bus.DMA_ACTIVE = 1'b0; bus.DMA_WR = 1'b0; bus.DMA_IDX = 8'h00; bus.DMA_DATA = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ppu_data", bus.PPU_DATA_in, 8'h00);
    check("reset_mmio_data", bus.MMIO_DATA_in, 8'hFF);

    // CPU write then PPU read: data appears exactly one cycle after the PPU_RD edge
    cpu_wr(16'h8010, 8'hA5);
    bus.PPU_ADDR = 16'h8010; bus.PPU_RD = 1'b1;
    #3;
    check("ppu_before_edge", bus.PPU_DATA_in, 8'h00);
    tick();
    bus.PPU_RD = 1'b0;
    check("ppu_one_cycle", bus.PPU_DATA_in, 8'hA5);
    tick();
    check("ppu_hold", bus.PPU_DATA_in, 8'hA5);

    vecs.push_back(mk(OP_W, 2'd0, 1'b1, 16'h9800, 8'h00, "w9800_m0"));
    vecs.push_back(mk(OP_W, 2'd3, 1'b1, 16'h9800, 8'h3C, "w9800_m3"));
    vecs.push_back(mk(OP_R, 2'd3, 1'b1, 16'h9800, 8'hFF, "r9800_m3_locked"));
    vecs.push_back(mk(OP_R, 2'd0, 1'b1, 16'h9800, 8'h00, "r9800_m0_dropped_wr"));
    vecs.push_back(mk(OP_W, 2'd0, 1'b1, 16'hFE00, 8'h5A, "wfe00_m0"));
    vecs.push_back(mk(OP_R, 2'd2, 1'b1, 16'hFE00, 8'hFF, "rfe00_m2_locked"));
    vecs.push_back(mk(OP_R, 2'd2, 1'b0, 16'hFE00, 8'h5A, "rfe00_m2_lcd_off"));
    vecs.push_back(mk(OP_R, 2'd3, 1'b1, 16'hFE00, 8'hFF, "rfe00_m3_locked"));
    vecs.push_back(mk(OP_R, 2'd1, 1'b1, 16'hFE00, 8'h5A, "rfe00_m1_open"));
    vecs.push_back(mk(OP_W, 2'd0, 1'b1, 16'hFE01, 8'h12, "wfe01_m0"));
    vecs.push_back(mk(OP_W, 2'd2, 1'b1, 16'hFE01, 8'h99, "wfe01_m2"));
    vecs.push_back(mk(OP_R, 2'd0, 1'b1, 16'hFE01, 8'h12, "rfe01_dropped_wr"));
    vecs.push_back(mk(OP_R, 2'd3, 1'b1, 16'h8010, 8'hFF, "r8010_m3_locked"));
    vecs.push_back(mk(OP_R, 2'd2, 1'b1, 16'h8010, 8'hA5, "r8010_m2_open"));
    vecs.push_back(mk(OP_R, 2'd3, 1'b0, 16'h8010, 8'hA5, "r8010_m3_lcd_off"));
    vecs.push_back(mk(OP_W, 2'd1, 1'b1, 16'h9FFF, 8'hC3, "w9fff_m1"));
    vecs.push_back(mk(OP_R, 2'd1, 1'b1, 16'h9FFF, 8'hC3, "r9fff_m1"));
    vecs.push_back(mk(OP_R, 2'd0, 1'b1, 16'hFEA0, 8'h00, "rfea0_hole"));
    vecs.push_back(mk(OP_R, 2'd0, 1'b1, 16'hA000, 8'hFF, "ra000_unclaimed"));
    vecs.push_back(mk(OP_R, 2'd0, 1'b1, 16'hFEFF, 8'h00, "rfeff_hole"));
    vecs.push_back(mk(OP_R, 2'd2, 1'b1, 16'hFEFF, 8'hFF, "rfeff_hole_locked"));
    vecs.push_back(mk(OP_P, 2'd3, 1'b1, 16'h8010, 8'hA5, "p8010_m3"));
    vecs.push_back(mk(OP_P, 2'd2, 1'b1, 16'hFE00, 8'h5A, "pfe00_m2"));
    vecs.push_back(mk(OP_P, 2'd0, 1'b1, 16'h0000, 8'h00, "p0000_unmapped"));
    vecs.push_back(mk(OP_P, 2'd3, 1'b1, 16'h9FFF, 8'hC3, "p9fff_m3"));
    vecs.push_back(mk(OP_P, 2'd0, 1'b1, 16'hFEA0, 8'h00, "pfea0_hole"));
    vecs.push_back(mk(OP_W, 2'd0, 1'b1, 16'h8000, 8'h11, "w8000_m0"));

    for (int i = 0; i < vecs.size(); i++) begin
      bus.PPU_MODE = vecs[i].mode;
      bus.LCD_EN   = vecs[i].lcd;
      case (vecs[i].op)
        OP_W: cpu_wr(vecs[i].addr, vecs[i].data);
        OP_R: begin cpu_rd(vecs[i].addr, got); check(vecs[i].name, got, vecs[i].data); end
        default: begin ppu_rd(vecs[i].addr, got); check(vecs[i].name, got, vecs[i].data); end
      endcase
    end
    bus.PPU_MODE = 2'd0;
    bus.LCD_EN   = 1'b1;

    // Lock is sampled at the request edge; a later mode change has no effect
    bus.ADDR = 16'h8010; bus.RD = 1'b1;
    tick();
    bus.RD = 1'b0; bus.PPU_MODE = 2'd3;
    tick();
    check("lock_at_request", bus.MMIO_DATA_in, 8'hA5);
    bus.PPU_MODE = 2'd0;

    // OAM DMA fill with a colliding CPU write and a PPU read mid-transfer
    bus.DMA_ACTIVE = 1'b1;
    tick();
    for (int idx = 0; idx < 160; idx++) begin
      bus.DMA_WR = 1'b1; bus.DMA_IDX = 8'(idx); bus.DMA_DATA = 8'(8'h10 + idx);
      bus.WR = (idx == 5); bus.ADDR = 16'hFE05; bus.MMIO_DATA_out = 8'hEE;
      bus.PPU_RD = (idx == 20); bus.PPU_ADDR = 16'hFE05;
      tick();
      if (idx == 20) check("ppu_oam_during_dma", bus.PPU_DATA_in, 8'hFF);
    end
    bus.WR = 1'b0; bus.PPU_RD = 1'b0;
    bus.DMA_IDX = 8'd160; bus.DMA_DATA = 8'h00;
    tick();
    bus.DMA_WR = 1'b0; bus.DMA_ACTIVE = 1'b0;
    tick();
    ppu_rd(16'hFE05, got);
    check("ppu_oam_after_dma", got, 8'h15);
    cpu_rd(16'hFE05, got);
    check("cpu_oam_dma_wins", got, 8'h15);

    // DMA priority over an unlocked CPU OAM write
    bus.DMA_WR = 1'b1; bus.DMA_IDX = 8'd6; bus.DMA_DATA = 8'h66;
    bus.WR = 1'b1; bus.ADDR = 16'hFE06; bus.MMIO_DATA_out = 8'hEE;
    tick();
    bus.DMA_WR = 1'b0; bus.WR = 1'b0;
    cpu_rd(16'hFE06, got);
    check("dma_priority_unlocked", got, 8'h66);
    cpu_rd(16'hFE9F, got);
    check("oam_last_index", got, 8'hAF);

    // Same-cycle PPU read and CPU write: read returns old data
    bus.PPU_ADDR = 16'h8000; bus.PPU_RD = 1'b1;
    bus.ADDR = 16'h8000; bus.WR = 1'b1; bus.MMIO_DATA_out = 8'h77;
    tick();
    bus.PPU_RD = 1'b0; bus.WR = 1'b0;
    check("collision_old_data", bus.PPU_DATA_in, 8'h11);
    ppu_rd(16'h8000, got);
    check("collision_new_data", got, 8'h77);

    // Reset arriving one cycle after a CPU read discards it
    bus.ADDR = 16'h8000; bus.RD = 1'b1;
    tick();
    bus.RD = 1'b0;
    check("mmio_latency", bus.MMIO_DATA_in, 8'hAF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mmio", bus.MMIO_DATA_in, 8'hFF);
    check("rst_ppu", bus.PPU_DATA_in, 8'h00);
    tick();
    check("rst_inflight_dropped", bus.MMIO_DATA_in, 8'hFF);
    cpu_rd(16'h8000, got);
    check("ram_retained_cpu", got, 8'h77);
    ppu_rd(16'h8000, got);
    check("ram_retained_ppu", got, 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_vram_responder.md
Name: ppu_vram_responder

Overview:
- Memory-side responder for the PPU fetch interface. It owns VRAM (0x8000–0x9FFF, 8 KiB) and OAM (0xFE00–0xFE9F, 160 B).
- It answers PPU reads with a fixed 1-cycle registered latency, inside the PPU's MEM_REQ→MEM_NO_REQ window.
- It arbitrates CPU MMIO reads and writes against PPU mode locking and an OAM DMA write port.
- It sits between the PPU and the CPU bus decoder.

Parameters:
- VRAM_AW, 13, VRAM address width (8 KiB).
- OAM_SIZE, 160, number of OAM bytes.
- LOCK_EN, 1, enable mode-based CPU access locking (0 = CPU is never locked).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- PPU_RD  in  1  PPU read strobe
- PPU_ADDR  in  16  PPU read address
- PPU_DATA_in  out  8  read data; drives the PPU's PPU_DATA_in net
- PPU_MODE  in  2  current PPU mode (0 HBLANK, 1 VBLANK, 2 SCAN, 3 DRAW)
- LCD_EN  in  1  LCDC[7]; when 0, all locking is disabled
- ADDR  in  16  CPU address
- WR  in  1  CPU write strobe
- RD  in  1  CPU read strobe
- MMIO_DATA_out  in  8  CPU write data
- MMIO_DATA_in  out  8  CPU read data
- DMA_ACTIVE  in  1  OAM DMA transfer in progress
- DMA_WR  in  1  DMA write strobe
- DMA_IDX  in  8  OAM byte index, 0–159
- DMA_DATA  in  8  DMA write data

Behaviour:
- Reset:
  - PPU_DATA_in = 8'h00, MMIO_DATA_in = 8'hFF.
  - The CPU read pipeline valid flag is cleared; an in-flight read is discarded.
  - RAM contents are not cleared.
- Address decode:
  - vram_sel = ADDR in 0x8000–0x9FFF.
  - oam_sel = ADDR in 0xFE00–0xFE9F.
  - 0xFEA0–0xFEFF is an unusable hole.
  - Any other address is not claimed by this block.
- Lock evaluation: locks are evaluated combinationally from PPU_MODE, LCD_EN and DMA_ACTIVE at the edge that samples the request. A mode change on a later cycle does not affect an accepted request.
  - vram_lock = LOCK_EN & LCD_EN & (PPU_MODE==3).
  - oam_lock = (LOCK_EN & LCD_EN & PPU_MODE[1]) | DMA_ACTIVE.
- PPU read path:
  - At an edge with PPU_RD=1, PPU_DATA_in <= the byte at PPU_ADDR. It is valid one cycle later and held until the next edge with PPU_RD=1.
  - The PPU is never locked out of VRAM or OAM, except that OAM reads return 8'hFF while DMA_ACTIVE.
  - PPU reads of the hole or of unmapped space return 8'h00.
- CPU read path (1-cycle latency):
  - An edge with RD=1 and vram_sel|oam_sel registers the request. At the next edge MMIO_DATA_in is loaded with the RAM byte.
  - It loads 8'hFF instead if the region was locked at request time.
  - Hole reads return 8'h00; locked hole reads return 8'hFF.
  - MMIO_DATA_in holds its value until the next claimed read.
  - MMIO_DATA_in returns to 8'hFF on the cycle after a non-claimed RD.
- CPU write path:
  - WR=1 to an unlocked region writes at that edge.
  - Writes to a locked region are dropped silently, with no queuing.
  - Writes to the hole are dropped.
- DMA write path:
  - DMA_WR=1 with DMA_IDX<160 writes OAM[DMA_IDX]; DMA_IDX≥160 is ignored.
  - DMA has absolute priority over a CPU OAM write in the same cycle; the CPU write is dropped.
- Collisions:
  - A same-cycle PPU read and CPU/DMA write to the same address returns the old data (read-before-write).
  - A same-cycle CPU read and CPU write to the same address is not possible on a single bus; no requirement.
- Implementation rules:
  - Address arithmetic uses 16-bit subtraction of the region base, truncated to VRAM_AW or 8 bits.
  - No combinational path from ADDR to MMIO_DATA_in other than the final claimed/unclaimed mux.

Decomposition:
- Shared package ppu_pkg:
  - PPU mode enum, reusing the PPU's H_BLANK/V_BLANK/SCAN/DRAW encoding.
  - Constants VRAM_BASE 16'h8000, VRAM_END 16'h9FFF, OAM_BASE 16'hFE00, OAM_END 16'hFE9F, HOLE_END 16'hFEFF.
- Sub-module ppu_dpram: synchronous true dual-port RAM (parameter AW, DEPTH), read-before-write per port. It is instantiated twice:
  - VRAM: port A serves PPU reads; port B serves CPU reads and writes.
  - OAM: port A serves PPU reads; port B serves CPU/DMA reads and writes through the DMA priority mux.

Test Plan:
- LCD_EN=1, mode 0: CPU WR 0x8010=8'hA5; PPU_RD 0x8010 next cycle → PPU_DATA_in=8'hA5 exactly one cycle after the PPU_RD edge.
- Mode 3: CPU WR 0x9800=8'h3C is dropped and CPU RD 0x9800 returns 8'hFF. In mode 0, CPU RD 0x9800 returns the prior value 8'h00.
- Mode 2: CPU RD 0xFE00 → 8'hFF. LCD_EN=0 with mode 2 forced → CPU RD 0xFE00 returns stored data.
- DMA_ACTIVE=1 with DMA writing indices 0..159 of 8'h10+idx, while the CPU writes 0xFE05=8'hEE in the same cycle as DMA idx 5 → OAM[5]=8'h15. A PPU read of 0xFE05 during DMA returns 8'hFF, and 8'h15 after DMA ends.
- Same-cycle PPU_RD 0x8000 and CPU WR 0x8000=8'h77 (old 8'h11) → PPU_DATA_in=8'h11; a subsequent read returns 8'h77.
- rst asserted the cycle after a CPU RD to 0x8000 → MMIO_DATA_in=8'hFF and PPU_DATA_in=8'h00 after reset. RAM contents are retained (re-read returns the old value).
